nios2_cpu_cpu_mult_seq: RTL and testbench

- Multi-cycle multiply sequencer: the initiator that drives the 16x16 partial-product multiplier cell and assembles its outputs into a full 64-bit product.
- Issues two passes to the cell and combines the partial products into `result_lo` (mul) and `result_hi` (mulxuu/mulxsu/mulxss).
- Sits between the E/M-stage operand muxes and the writeback result mux.

---
 rtl/nios2_cpu_cpu_mult_seq.sv | 194 +++++++++++++++++++
 tb/tb_nios2_cpu_cpu_mult_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nios2_cpu_cpu_mult_seq.sv
// Multi-cycle multiply sequencer: runs two passes through the 16x16 partial-product
// cell and folds the partial products into a 64-bit product with signedness correction.
module nios2_cpu_cpu_mult_seq #(
  parameter int unsigned CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        ready,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  output logic        mul_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  localparam int unsigned CW = 2;
  localparam int unsigned DW = 32;
  // Last wait-counter value before capture; pass 1 has one cycle less because ISSUE1 counts.
  localparam logic [CW-1:0] W1_LAST = CW'(CELL_LATENCY - 2);
  localparam logic [CW-1:0] W2_LAST = CW'(CELL_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, FIX, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            ready_next, done_next, mul_en_next;
  logic [DW-1:0]   src1_next, src2_next;
  logic            accept_c, cap1_c, cap2_c, fix_c;

  logic [DW-1:0]   a_q, b_q;
  logic [1:0]      op_q;
  logic [DW-1:0]   pp_lo, pp_hh;
  logic [DW:0]     mid;
  logic [2*DW-1:0] prod_c;
  logic [DW-1:0]   corr_a_c, corr_b_c, hi_corr_c;

  // State and wait-counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, registered-output next values and datapath strobes
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    ready_next  = 1'b0;
    done_next   = 1'b0;
    mul_en_next = 1'b0;
    src1_next   = mul_src1;
    src2_next   = mul_src2;
    accept_c    = 1'b0;
    cap1_c      = 1'b0;
    cap2_c      = 1'b0;
    fix_c       = 1'b0;
    case (state)
      IDLE: begin
        src1_next = '0;
        src2_next = '0;
        if (start) begin
          accept_c    = 1'b1;
          state_next  = ISSUE1;
          mul_en_next = 1'b1;
          src1_next   = op_a;
          src2_next   = op_b;
        end else begin
          ready_next = 1'b1;
        end
      end
      ISSUE1: begin
        cnt_next = '0;
        if (CELL_LATENCY == 1) begin
          cap1_c      = 1'b1;
          state_next  = ISSUE2;
          mul_en_next = 1'b1;
          src1_next   = {16'h0, a_q[31:16]};
          src2_next   = {16'h0, b_q[31:16]};
        end else begin
          state_next = WAIT1;
        end
      end
      WAIT1: begin
        if (cnt == W1_LAST) begin
          cap1_c      = 1'b1;
          state_next  = ISSUE2;
          mul_en_next = 1'b1;
          src1_next   = {16'h0, a_q[31:16]};
          src2_next   = {16'h0, b_q[31:16]};
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      ISSUE2: begin
        cnt_next   = '0;
        state_next = WAIT2;
      end
      WAIT2: begin
        if (cnt == W2_LAST) begin
          cap2_c     = 1'b1;
          state_next = FIX;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      FIX: begin
        fix_c      = 1'b1;
        done_next  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        ready_next = 1'b1;
        src1_next  = '0;
        src2_next  = '0;
        state_next = IDLE;
      end
      default: begin
        ready_next = 1'b1;
        src1_next  = '0;
        src2_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Registered handshake and cell-drive outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready    <= 1'b1;
      done     <= 1'b0;
      mul_en   <= 1'b0;
      mul_src1 <= '0;
      mul_src2 <= '0;
    end else begin
      ready    <= ready_next;
      done     <= done_next;
      mul_en   <= mul_en_next;
      mul_src1 <= src1_next;
      mul_src2 <= src2_next;
    end
  end

  // Unsigned product assembly, then subtract the cross terms for signed operands
  always_comb begin
    prod_c    = {pp_hh, 32'h0} + ({31'h0, mid} << 16) + {32'h0, pp_lo};
    corr_a_c  = (a_q[31] && (op_q == 2'b01 || op_q == 2'b10)) ? b_q : '0;
    corr_b_c  = (b_q[31] && (op_q == 2'b10)) ? a_q : '0;
    hi_corr_c = prod_c[63:32] - corr_a_c - corr_b_c;
  end

  // Operand latches, partial-product captures and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      pp_lo     <= '0;
      pp_hh     <= '0;
      mid       <= '0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      if (accept_c) begin
        a_q  <= op_a;
        b_q  <= op_b;
        op_q <= op;
      end
      if (cap1_c) begin
        pp_lo <= cell_p1;
        mid   <= {1'b0, cell_p2} + {1'b0, cell_p3};
      end
      if (cap2_c) begin
        pp_hh <= cell_p1;
      end
      if (fix_c) begin
        result_lo <= prod_c[31:0];
        result_hi <= hi_corr_c;
      end
    end
  end

endmodule

// File: tb/tb_nios2_cpu_cpu_mult_seq.sv
// Scoreboard bench: latency-1 instance with a combinational cell for directed vectors,
// latency-2 instance with a registered cell for random operands against a 64-bit model.
module tb_nios2_cpu_cpu_mult_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start1 = 1'b0, start2 = 1'b0;
  logic [1:0]  op1 = '0, op2 = '0;
  logic [31:0] a1 = '0, b1 = '0, a2 = '0, b2 = '0;
  logic        ready1, done1, en1, ready2, done2, en2;
  logic [31:0] lo1, hi1, s1_1, s2_1, lo2, hi2, s1_2, s2_2;
  logic [31:0] p1_1, p2_1, p3_1;
  logic [31:0] p1_2 = '0, p2_2 = '0, p3_2 = '0;

  nios2_cpu_cpu_mult_seq #(.CELL_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .op(op1), .op_a(a1), .op_b(b1),
    .ready(ready1), .done(done1), .result_lo(lo1), .result_hi(hi1),
    .mul_src1(s1_1), .mul_src2(s2_1), .mul_en(en1),
    .cell_p1(p1_1), .cell_p2(p2_1), .cell_p3(p3_1));

  nios2_cpu_cpu_mult_seq #(.CELL_LATENCY(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .op(op2), .op_a(a2), .op_b(b2),
    .ready(ready2), .done(done2), .result_lo(lo2), .result_hi(hi2),
    .mul_src1(s1_2), .mul_src2(s2_2), .mul_en(en2),
    .cell_p1(p1_2), .cell_p2(p2_2), .cell_p3(p3_2));

  // Latency-1 cell: product of the operands currently presented
  assign p1_1 = {16'h0, s1_1[15:0]} * {16'h0, s2_1[15:0]};
  assign p2_1 = {16'h0, s1_1[15:0]} * {16'h0, s2_1[31:16]};
  assign p3_1 = {16'h0, s1_1[31:16]} * {16'h0, s2_1[15:0]};

  // Latency-2 cell: products registered on an enabled edge and held
  always @(posedge clk) begin
    if (en2) begin
      p1_2 <= {16'h0, s1_2[15:0]} * {16'h0, s2_2[15:0]};
      p2_2 <= {16'h0, s1_2[15:0]} * {16'h0, s2_2[31:16]};
      p3_2 <= {16'h0, s1_2[31:16]} * {16'h0, s2_2[15:0]};
    end
  end

  typedef struct { logic [63:0] prod; int acc; } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt1 = 0;
  logic [31:0] p2s1 = '0, p2s2 = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ax, bx;
    ax = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    bx = (op == 2'b10) ? {{32{b[31]}}, b} : {32'h0, b};
    return ax * bx;
  endfunction

  // Monitor: pops the scoreboard whenever a done pulse is seen
  always @(negedge clk) begin
    exp_t e;
    if (en1) begin
      if (en_cnt1 % 2 == 1) begin
        p2s1 = s1_1;
        p2s2 = s2_1;
      end
      en_cnt1++;
    end
    if (done1) begin
      if (q1.size() == 0) fail_now("d1_unexpected_done");
      else begin
        e = q1.pop_front();
        chk("d1_lo", 64'(lo1), 64'(e.prod[31:0]));
        chk("d1_hi", 64'(hi1), 64'(e.prod[63:32]));
        chk("d1_latency", 64'(cyc - e.acc + 1), 64'd5);
      end
    end
    if (done2) begin
      if (q2.size() == 0) fail_now("d2_unexpected_done");
      else begin
        e = q2.pop_front();
        chk("d2_lo", 64'(lo2), 64'(e.prod[31:0]));
        chk("d2_hi", 64'(hi2), 64'(e.prod[63:32]));
        chk("d2_latency", 64'(cyc - e.acc + 1), 64'd7);
      end
    end
  end

  task automatic issue(input int inst, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] expv);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!(inst == 1 ? ready1 : ready2) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!(inst == 1 ? ready1 : ready2)) begin
      fail_now("ready_timeout");
      return;
    end
    e.prod = expv;
    e.acc  = cyc + 1;
    if (inst == 1) begin
      start1 = 1'b1; op1 = op; a1 = a; b1 = b;
      q1.push_back(e);
    end else begin
      start2 = 1'b1; op2 = op; a2 = a; b2 = b;
      q2.push_back(e);
    end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic drain(input int inst);
    int w;
    w = 0;
    while ((inst == 1 ? q1.size() : q2.size()) != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if ((inst == 1 ? q1.size() : q2.size()) != 0) fail_now("done_timeout");
  endtask

  initial begin
    int base;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    chk("rst_ready1", 64'(ready1), 64'd1);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_lo1", 64'(lo1), 64'd0);
    chk("rst_hi1", 64'(hi1), 64'd0);
    chk("rst_en1", 64'(en1), 64'd0);
    chk("rst_src1", 64'({s1_1, s2_1}), 64'd0);
    chk("rst_ready2", 64'(ready2), 64'd1);
    reset_n = 1'b1;

    base = en_cnt1;
    issue(1, 2'b00, 32'h3, 32'h5, 64'h0000_0000_0000_000F);
    drain(1);
    chk("t1_en_pulses", 64'(en_cnt1 - base), 64'd2);
    chk("t1_pass2_src", 64'({p2s1, p2s2}), 64'd0);

    issue(1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    issue(1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
    issue(1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    issue(1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    issue(1, 2'b10, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    issue(1, 2'b10, 32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000);
    drain(1);

    // Busy start is dropped; the following request lands the cycle after done
    issue(1, 2'b00, 32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF);
    chk("busy_ready_low", 64'(ready1), 64'd0);
    start1 = 1'b1; op1 = 2'b10; a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF;
    @(negedge clk);
    start1 = 1'b0;
    issue(1, 2'b00, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    drain(1);

    // Reset while in WAIT2
    issue(1, 2'b01, 32'h7, 32'h9, 64'd63);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(ready1), 64'd1);
    chk("mid_rst_done", 64'(done1), 64'd0);
    chk("mid_rst_result", 64'({hi1, lo1}), 64'd0);
    chk("mid_rst_en", 64'(en1), 64'd0);
    q1.delete();
    @(negedge clk);
    reset_n = 1'b1;
    issue(1, 2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
    drain(1);

    // Latency-2 instance against the reference model
    for (int i = 0; i < 1000; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 10 == 0) ra = {1'b1, ra[30:0]};
      if (i % 10 == 1) rb = {1'b1, rb[30:0]};
      issue(2, rop, ra, rb, ref_mul(rop, ra, rb));
    end
    drain(2);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
